// File: rtl/seq_match_logger.sv
// seq_match_logger: counts single-cycle match pulses from the seq_1100
// detector and logs a free-running timestamp for each one in a small
// first-word-fall-through FIFO, with a sticky overflow flag for lost entries.
module seq_match_logger #(
    parameter int TS_WIDTH  = 16,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 y,
    input  logic                 clr,
    input  logic                 rd_en,
    output logic [TS_WIDTH-1:0]  ts_out,
    output logic                 empty,
    output logic                 full,
    output logic [CNT_WIDTH-1:0] match_count,
    output logic                 overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [TS_WIDTH-1:0]  ts;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [TS_WIDTH-1:0]  mem [DEPTH];

    logic                 do_wr;
    logic                 do_rd;
    logic                 drop;
    logic                 cnt_sat;

    // Status decode from the pointer registers only; the extra MSB tells
    // a full ring apart from an empty one when the index bits match.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign ts_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Per-edge decisions, all taken from pre-edge state; clr masks everything.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block can leave it unassigned and infer a latch.
        do_wr   = 1'b0;
        do_rd   = 1'b0;
        drop    = 1'b0;
        cnt_sat = (match_count == {CNT_WIDTH{1'b1}});
        if (!clr) begin
            do_wr = y && !full;
            drop  = y && full;
            do_rd = rd_en && !empty;
        end
    end

    // Free-running timestamp; keeps counting through clr and wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) ts <= '0;
        else     ts <= ts + TS_WIDTH'(1);
    end

    // Match counter, sticky overflow and FIFO pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_count <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else if (clr) begin
            match_count <= '0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            if (y && !cnt_sat) match_count <= match_count + CNT_WIDTH'(1);
            if (drop)          overflow    <= 1'b1;
            if (do_wr)         wr_ptr      <= wr_ptr + (AW+1)'(1);
            if (do_rd)         rd_ptr      <= rd_ptr + (AW+1)'(1);
        end
    end

    // Timestamp storage; the tail slot captures ts as it was before this edge.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; entries are only visible
        // through the pointers, which are reset, so clearing data is wasted.
        if (do_wr) mem[wr_ptr[AW-1:0]] <= ts;
    end

endmodule

// File: tb/tb_seq_match_logger.sv
// Directed self-checking bench for seq_match_logger: dut_a uses default
// parameters, dut_b uses 4-bit timestamp and counter for saturation/wrap.
module tb_seq_match_logger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        ya = 1'b0, clra = 1'b0, rda = 1'b0;
    logic [15:0] ts_out_a;
    logic        empty_a, full_a, overflow_a;
    logic [7:0]  count_a;

    logic        yb = 1'b0, clrb = 1'b0, rdb = 1'b0;
    logic [3:0]  ts_out_b;
    logic        empty_b, full_b, overflow_b;
    logic [3:0]  count_b;

    int checks   = 0;
    int failures = 0;
    int tb_ts    = 0;   // expected value of the DUT timestamp between edges
    int ev_ts[$];
    int prev_obs;

    seq_match_logger dut_a (
        .clk(clk), .rst(rst), .y(ya), .clr(clra), .rd_en(rda),
        .ts_out(ts_out_a), .empty(empty_a), .full(full_a),
        .match_count(count_a), .overflow(overflow_a)
    );

    seq_match_logger #(.TS_WIDTH(4), .DEPTH(4), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst), .y(yb), .clr(clrb), .rd_en(rdb),
        .ts_out(ts_out_b), .empty(empty_b), .full(full_b),
        .match_count(count_b), .overflow(overflow_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: wait for the edge, track the timestamp, sample 1ns later.
    task automatic step();
        @(posedge clk);
        if (!rst) tb_ts++;
        #1;
    endtask

    task automatic pop_a();
        rda = 1'b1; step(); rda = 1'b0;
    endtask

    task automatic clear_a();
        clra = 1'b1; step(); clra = 1'b0;
        ev_ts.delete();
    endtask

    initial begin
        // Reset then idle
        step(); step();
        rst = 1'b0; tb_ts = 0;
        chk("rst_empty_a", 32'(empty_a), 1);
        chk("rst_full_a", 32'(full_a), 0);
        chk("rst_ts_out_a", 32'(ts_out_a), 0);
        chk("rst_count_b", 32'(count_b), 0);
        chk("rst_empty_b", 32'(empty_b), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_empty", 32'(empty_a), 1);
            chk("idle_ts_out", 32'(ts_out_a), 0);
            chk("idle_count", 32'(count_a), 0);
            chk("idle_overflow", 32'(overflow_a), 0);
        end

        // Single match at ts=5 after a fresh reset
        rst = 1'b1; step(); rst = 1'b0; tb_ts = 0;
        while (tb_ts != 5) step();
        ya = 1'b1; step(); ya = 1'b0;
        chk("single_count", 32'(count_a), 1);
        chk("single_empty", 32'(empty_a), 0);
        chk("single_ts_out", 32'(ts_out_a), 5);
        pop_a();
        chk("single_pop_empty", 32'(empty_a), 1);
        chk("single_pop_ts_out", 32'(ts_out_a), 0);

        // Detector stream 0011000111100110 1100: y pulses where 1100 completes
        clear_a();
        for (int i = 0; i < 20; i++) begin
            ya = (i == 5 || i == 12 || i == 19);
            if (ya) ev_ts.push_back(tb_ts);
            step();
        end
        ya = 1'b0;
        chk("stream_count", 32'(count_a), 3);
        for (int k = 0; k < 3; k++) begin
            chk("stream_ts", 32'(ts_out_a), 32'(ev_ts[k]));
            if (k > 0) chk("stream_spacing", 32'(int'(ts_out_a) - prev_obs), 7);
            prev_obs = int'(ts_out_a);
            pop_a();
        end
        chk("stream_drained", 32'(empty_a), 1);

        // Overflow: five back-to-back events, no reads
        clear_a();
        for (int i = 0; i < 5; i++) begin
            ya = 1'b1; ev_ts.push_back(tb_ts); step();
            if (i == 3) begin
                chk("ovf_full_at4", 32'(full_a), 1);
                chk("ovf_not_yet", 32'(overflow_a), 0);
            end
        end
        ya = 1'b0;
        chk("ovf_count", 32'(count_a), 5);
        chk("ovf_flag", 32'(overflow_a), 1);
        chk("ovf_full", 32'(full_a), 1);
        for (int k = 0; k < 4; k++) begin
            chk("ovf_pop_ts", 32'(ts_out_a), 32'(ev_ts[k]));
            pop_a();
        end
        chk("ovf_drained", 32'(empty_a), 1);
        chk("ovf_sticky", 32'(overflow_a), 1);

        // Simultaneous event + pop while full
        clear_a();
        for (int i = 0; i < 4; i++) begin
            ya = 1'b1; ev_ts.push_back(tb_ts); step();
        end
        ya = 1'b1; rda = 1'b1; step(); ya = 1'b0; rda = 1'b0;
        chk("simfull_not_full", 32'(full_a), 0);
        chk("simfull_overflow", 32'(overflow_a), 1);
        for (int k = 1; k < 4; k++) begin
            chk("simfull_ts", 32'(ts_out_a), 32'(ev_ts[k]));
            pop_a();
        end
        chk("simfull_occ3", 32'(empty_a), 1);

        // Simultaneous event + pop while empty
        clear_a();
        ya = 1'b1; rda = 1'b1; ev_ts.push_back(tb_ts); step(); ya = 1'b0; rda = 1'b0;
        chk("simempty_not_empty", 32'(empty_a), 0);
        chk("simempty_head", 32'(ts_out_a), 32'(ev_ts[0]));
        pop_a();
        chk("simempty_occ1", 32'(empty_a), 1);

        // Saturation on the 4-bit counter
        clrb = 1'b1; step(); clrb = 1'b0;
        yb = 1'b1;
        for (int i = 0; i < 17; i++) step();
        yb = 1'b0;
        chk("sat_count", 32'(count_b), 15);
        chk("sat_overflow", 32'(overflow_b), 1);

        // Timestamp wrap 15 -> 0
        clrb = 1'b1; step(); clrb = 1'b0;
        while ((tb_ts % 16) != 15) step();
        yb = 1'b1; step(); step(); yb = 1'b0;
        chk("wrap_ts15", 32'(ts_out_b), 15);
        rdb = 1'b1; step(); rdb = 1'b0;
        chk("wrap_ts0", 32'(ts_out_b), 0);
        chk("wrap_one_left", 32'(empty_b), 0);

        // clr overrides a same-cycle event
        clrb = 1'b1; yb = 1'b1; step(); clrb = 1'b0; yb = 1'b0;
        chk("clr_count", 32'(count_b), 0);
        chk("clr_overflow", 32'(overflow_b), 0);
        chk("clr_empty", 32'(empty_b), 1);

        // Asynchronous reset between edges with two entries held
        clear_a();
        ya = 1'b1; step(); step(); ya = 1'b0;
        chk("async_pre_count", 32'(count_a), 2);
        chk("async_pre_empty", 32'(empty_a), 0);
        #2 rst = 1'b1;
        #1;
        chk("async_empty", 32'(empty_a), 1);
        chk("async_count", 32'(count_a), 0);
        chk("async_ts_out", 32'(ts_out_a), 0);
        #1 rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
